// File: rtl/snitch_regfile_wb_arbiter.sv
// Writeback arbiter and register scoreboard for the integer register file.
// Up to NrReq writeback sources share the single write port under round-robin
// arbitration. A busy bit per register tracks outstanding writes so issue
// logic can stall on RAW/WAW hazards.
module snitch_regfile_wb_arbiter #(
  parameter int unsigned NrReq       = 3,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 5,
  parameter int unsigned ZeroRegZero = 1,
  parameter int unsigned NrChk       = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NrReq-1:0]             wb_valid_i,
  output logic [NrReq-1:0]             wb_ready_o,
  input  logic [NrReq*AddrWidth-1:0]   wb_addr_i,
  input  logic [NrReq*DataWidth-1:0]   wb_data_i,
  output logic                         rf_we_o,
  output logic [AddrWidth-1:0]         rf_waddr_o,
  output logic [DataWidth-1:0]         rf_wdata_o,
  input  logic                         sb_set_i,
  input  logic [AddrWidth-1:0]         sb_set_addr_i,
  input  logic [NrChk*AddrWidth-1:0]   chk_addr_i,
  output logic [NrChk-1:0]             chk_busy_o,
  output logic [(2**AddrWidth)-1:0]    busy_o
);

  localparam int unsigned NumWords = 2 ** AddrWidth;
  localparam int unsigned RrW      = (NrReq > 1) ? $clog2(NrReq) : 1;
  localparam logic [RrW:0] NrReqW  = (RrW + 1)'(NrReq);

  logic [RrW-1:0]       rr_q, rr_d;
  logic [NumWords-1:0]  busy_q, busy_d;

  logic                 gnt_found_s;
  logic [RrW-1:0]       gnt_idx_s;
  logic [RrW:0]         cand_sum_s;
  logic [RrW-1:0]       cand_s;
  logic [RrW:0]         rr_nxt_s;
  logic [NrReq-1:0]     ready_s;
  logic [AddrWidth-1:0] gnt_addr_s;
  logic [DataWidth-1:0] gnt_data_s;
  logic                 zero_wr_s;
  logic                 set_ok_s;

  // Round-robin search: first valid requester at or after rr_q, wrapping.
  // Reset blocks any handshake so nothing is written while rst_ni is low.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_sum_s  = '0;
    cand_s      = '0;
    for (int i = 0; i < NrReq; i++) begin
      cand_sum_s = {1'b0, rr_q} + (RrW + 1)'(i);
      if (cand_sum_s >= NrReqW) begin
        cand_sum_s = cand_sum_s - NrReqW;
      end else begin
        cand_sum_s = cand_sum_s;
      end
      cand_s = cand_sum_s[RrW-1:0];
      if (!gnt_found_s && wb_valid_i[cand_s] && rst_ni) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // One-hot ready and selection of the granted requester's address and data.
  always_comb begin
    ready_s    = '0;
    gnt_addr_s = '0;
    gnt_data_s = '0;
    for (int j = 0; j < NrReq; j++) begin
      if (gnt_found_s && (gnt_idx_s == RrW'(j))) begin
        ready_s[j] = 1'b1;
        gnt_addr_s = wb_addr_i[j*AddrWidth +: AddrWidth];
        gnt_data_s = wb_data_i[j*DataWidth +: DataWidth];
      end else begin
        ready_s[j] = 1'b0;
      end
    end
  end

  // A write to the hardwired zero register is acknowledged but never reaches the file.
  always_comb begin
    if ((ZeroRegZero != 32'd0) && (gnt_addr_s == '0)) begin
      zero_wr_s = 1'b1;
    end else begin
      zero_wr_s = 1'b0;
    end
  end

  // Pointer moves to the requester after the winner; holds when idle.
  always_comb begin
    rr_nxt_s = '0;
    if (gnt_found_s) begin
      rr_nxt_s = {1'b0, gnt_idx_s} + (RrW + 1)'(1);
      if (rr_nxt_s >= NrReqW) begin
        rr_nxt_s = '0;
      end else begin
        rr_nxt_s = rr_nxt_s;
      end
      rr_d = rr_nxt_s[RrW-1:0];
    end else begin
      rr_d = rr_q;
    end
  end

  // Scoreboard update: clear on granted write, then set from issue so set wins.
  always_comb begin
    busy_d   = busy_q;
    set_ok_s = sb_set_i;
    if (gnt_found_s) begin
      busy_d[gnt_addr_s] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if ((ZeroRegZero != 32'd0) && (sb_set_addr_i == '0)) begin
      set_ok_s = 1'b0;
    end else begin
      set_ok_s = set_ok_s;
    end
    if (set_ok_s) begin
      busy_d[sb_set_addr_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    if (ZeroRegZero != 32'd0) begin
      busy_d[0] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
  end

  // State registers: pointer and busy vector, both cleared by async reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      busy_q <= '0;
    end else begin
      rr_q   <= rr_d;
      busy_q <= busy_d;
    end
  end

  // Hazard lookups read the registered busy bits only (no same-cycle bypass).
  always_comb begin
    chk_busy_o = '0;
    for (int k = 0; k < NrChk; k++) begin
      chk_busy_o[k] = busy_q[chk_addr_i[k*AddrWidth +: AddrWidth]];
    end
  end

  assign wb_ready_o = ready_s;
  assign rf_we_o    = gnt_found_s & ~zero_wr_s;
  assign rf_waddr_o = gnt_addr_s;
  assign rf_wdata_o = gnt_data_s;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_snitch_regfile_wb_arbiter.sv
// Self-checking bench for snitch_regfile_wb_arbiter: directed scenarios plus
// randomized traffic checked against a behavioural model of grants and busy bits.
module tb_snitch_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NC = 2;
  localparam int NW = 32;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      valid;
  logic [N-1:0]      ready;
  logic [N*AW-1:0]   addr_f;
  logic [N*DW-1:0]   data_f;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;
  logic [NC*AW-1:0]  chk_f;
  logic [NC-1:0]     chk_busy;
  logic [NW-1:0]     busy;

  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_data [N];
  logic [AW-1:0] c_addr [NC];

  int m_rr;
  logic [NW-1:0] m_busy;
  int n_cmp = 0;
  int n_err = 0;

  snitch_regfile_wb_arbiter #(
    .NrReq(N), .DataWidth(DW), .AddrWidth(AW), .ZeroRegZero(1), .NrChk(NC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wb_valid_i(valid), .wb_ready_o(ready),
    .wb_addr_i(addr_f), .wb_data_i(data_f),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .sb_set_i(sb_set), .sb_set_addr_i(sb_addr),
    .chk_addr_i(chk_f), .chk_busy_o(chk_busy), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack per-requester arrays onto the flat DUT buses.
  task automatic drive();
    for (int j = 0; j < N; j++) begin
      addr_f[j*AW +: AW] = r_addr[j];
      data_f[j*DW +: DW] = r_data[j];
    end
    for (int k = 0; k < NC; k++) chk_f[k*AW +: AW] = c_addr[k];
  endtask

  // Reference grant: first valid index at or after the pointer, modulo N.
  function automatic int model_grant();
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (m_rr + i) % N;
      if (rst_n && valid[idx]) return idx;
    end
    return -1;
  endfunction

  // Advance one clock, updating the model with the inputs seen at that edge.
  task automatic tick();
    int g;
    g = model_grant();
    if (rst_n) begin
      if (g >= 0) begin
        m_rr = (g + 1) % N;
        m_busy[r_addr[g]] = 1'b0;
      end
      if (sb_set && sb_addr != 5'd0) m_busy[sb_addr] = 1'b1;
      m_busy[0] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; valid = '0; sb_set = 1'b0; sb_addr = '0;
    for (int j = 0; j < N; j++) begin r_addr[j] = '0; r_data[j] = '0; end
    for (int k = 0; k < NC; k++) c_addr[k] = '0;
    drive();
    m_rr = 0; m_busy = '0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 3'b111; sb_set = 1'b1; sb_addr = 5'd4;
    for (int j = 0; j < N; j++) begin r_addr[j] = 5'(j + 1); r_data[j] = 32'(j + 100); end
    for (int k = 0; k < NC; k++) c_addr[k] = 5'd4;
    drive();
    m_rr = 0; m_busy = '0;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we got=%b exp=0", rf_we); end
    n_cmp++; if (busy !== 32'h0) begin n_err++; $display("FAIL reset_busy got=%h exp=0", busy); end
    n_cmp++; if (ready !== 3'b000) begin n_err++; $display("FAIL reset_ready got=%b exp=000", ready); end
    n_cmp++; if (chk_busy !== 2'b00) begin n_err++; $display("FAIL reset_chk got=%b exp=00", chk_busy); end
    sb_set = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++; if (ready !== 3'b001) begin n_err++; $display("FAIL reset_first_grant got=%b exp=001", ready); end
    n_cmp++; if (rf_waddr !== 5'd1) begin n_err++; $display("FAIL reset_first_addr got=%0d exp=1", rf_waddr); end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    sb_set = 1'b1; sb_addr = 5'd3; drive(); tick();
    sb_addr = 5'd4; tick();
    sb_set = 1'b0; drive(); #1;
    n_cmp++; if (busy !== 32'h18) begin n_err++; $display("FAIL midop_pre got=%h exp=18", busy); end
    valid = 3'b001; r_addr[0] = 5'd3; r_data[0] = 32'h55; drive();
    #2 rst_n = 1'b0; #1;
    n_cmp++; if (busy !== 32'h0) begin n_err++; $display("FAIL midop_busy got=%h exp=0", busy); end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL midop_we got=%b exp=0", rf_we); end
    n_cmp++; if (ready !== 3'b000) begin n_err++; $display("FAIL midop_ready got=%b exp=000", ready); end
    m_rr = 0; m_busy = '0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 32'h0) begin n_err++; $display("FAIL midop_hold got=%h exp=0", busy); end
    valid = '0; @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy;
    apply_reset();
    valid = 3'b111;
    for (int j = 0; j < N; j++) begin r_addr[j] = 5'(j + 1); r_data[j] = $urandom; end
    drive();
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_rdy = 3'b001 << (c % 3);
      n_cmp++; if (ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, ready, exp_rdy); end
      n_cmp++; if (rf_waddr !== 5'((c % 3) + 1)) begin n_err++; $display("FAIL rr_addr c=%0d got=%0d exp=%0d", c, rf_waddr, (c % 3) + 1); end
      n_cmp++; if (rf_wdata !== r_data[c % 3]) begin n_err++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, rf_wdata, r_data[c % 3]); end
      tick();
    end
    valid = '0;
  endtask

  task automatic test_partial();
    int exp_seq [3] = '{2, 0, 2};
    apply_reset();
    valid = 3'b001; r_addr[0] = 5'd4; r_data[0] = 32'h4; drive(); #1;
    n_cmp++; if (ready !== 3'b001) begin n_err++; $display("FAIL partial_pre got=%b exp=001", ready); end
    tick();
    valid = 3'b101; r_addr[0] = 5'd6; r_addr[2] = 5'd8; r_data[2] = 32'h8; drive();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (ready !== (3'b001 << exp_seq[c])) begin
        n_err++; $display("FAIL partial_grant c=%0d got=%b exp_idx=%0d", c, ready, exp_seq[c]);
      end
      tick();
    end
    valid = '0;
  endtask

  task automatic test_scoreboard();
    apply_reset();
    c_addr[0] = 5'd5; c_addr[1] = 5'd6;
    sb_set = 1'b1; sb_addr = 5'd5; drive(); #1;
    n_cmp++; if (chk_busy[0] !== 1'b0) begin n_err++; $display("FAIL sb_before got=%b exp=0", chk_busy[0]); end
    tick();
    sb_set = 1'b0; drive();
    for (int c = 1; c <= 2; c++) begin
      #1;
      n_cmp++; if (chk_busy[0] !== 1'b1) begin n_err++; $display("FAIL sb_held c=%0d got=%b exp=1", c, chk_busy[0]); end
      tick();
    end
    valid = 3'b010; r_addr[1] = 5'd5; r_data[1] = 32'hDEADBEEF; drive(); #1;
    n_cmp++; if (chk_busy[0] !== 1'b1) begin n_err++; $display("FAIL sb_wrcycle got=%b exp=1", chk_busy[0]); end
    n_cmp++; if (ready !== 3'b010) begin n_err++; $display("FAIL sb_ready got=%b exp=010", ready); end
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5) begin n_err++; $display("FAIL sb_write got=%b/%0d exp=1/5", rf_we, rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sb_wdata got=%h exp=deadbeef", rf_wdata); end
    tick();
    valid = '0; drive(); #1;
    n_cmp++; if (chk_busy !== 2'b00) begin n_err++; $display("FAIL sb_release got=%b exp=00", chk_busy); end
  endtask

  task automatic test_collision();
    apply_reset();
    sb_set = 1'b1; sb_addr = 5'd7; drive(); tick();
    valid = 3'b001; r_addr[0] = 5'd7; r_data[0] = 32'h77; drive(); tick();
    valid = '0; sb_set = 1'b0; drive(); #1;
    n_cmp++; if (busy[7] !== 1'b1) begin n_err++; $display("FAIL coll_same got=%b exp=1", busy[7]); end
    valid = 3'b001; sb_set = 1'b1; sb_addr = 5'd9; drive(); tick();
    valid = '0; sb_set = 1'b0; drive(); #1;
    n_cmp++; if (busy[7] !== 1'b0 || busy[9] !== 1'b1) begin n_err++; $display("FAIL coll_diff got=%b%b exp=01", busy[7], busy[9]); end
  endtask

  task automatic test_zero_reg();
    apply_reset();
    sb_set = 1'b1; sb_addr = 5'd0;
    valid = 3'b001; r_addr[0] = 5'd0; r_data[0] = 32'h1234; drive(); #1;
    n_cmp++; if (ready !== 3'b001) begin n_err++; $display("FAIL zero_ready got=%b exp=001", ready); end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL zero_we got=%b exp=0", rf_we); end
    tick();
    sb_set = 1'b0; valid = 3'b111;
    for (int j = 0; j < N; j++) r_addr[j] = 5'(j + 1);
    drive(); #1;
    n_cmp++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL zero_busy got=%b exp=0", busy[0]); end
    n_cmp++; if (ready !== 3'b010) begin n_err++; $display("FAIL zero_rr got=%b exp=010", ready); end
    valid = '0;
  endtask

  task automatic test_random();
    int g;
    int wait_cnt [N];
    logic [N-1:0] exp_rdy;
    apply_reset();
    for (int j = 0; j < N; j++) wait_cnt[j] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < N; j++) begin
        if (!valid[j] && $urandom_range(0, 1) == 1) begin
          valid[j] = 1'b1; r_addr[j] = 5'($urandom_range(0, 31)); r_data[j] = $urandom;
        end
      end
      sb_set = ($urandom_range(0, 2) == 0); sb_addr = 5'($urandom_range(0, 31));
      for (int k = 0; k < NC; k++) c_addr[k] = 5'($urandom_range(0, 31));
      drive(); #1;
      g = model_grant();
      exp_rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
      n_cmp++; if (ready !== exp_rdy) begin n_err++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, ready, exp_rdy); end
      n_cmp++;
      if (rf_we !== (g >= 0 && r_addr[g] != 5'd0)) begin n_err++; $display("FAIL rnd_we c=%0d got=%b", c, rf_we); end
      n_cmp++;
      if (rf_waddr !== ((g >= 0) ? r_addr[g] : 5'd0)) begin n_err++; $display("FAIL rnd_waddr c=%0d got=%0d", c, rf_waddr); end
      n_cmp++;
      if (rf_wdata !== ((g >= 0) ? r_data[g] : 32'd0)) begin n_err++; $display("FAIL rnd_wdata c=%0d got=%h", c, rf_wdata); end
      n_cmp++; if (busy !== m_busy) begin n_err++; $display("FAIL rnd_busy c=%0d got=%h exp=%h", c, busy, m_busy); end
      for (int k = 0; k < NC; k++) begin
        n_cmp++;
        if (chk_busy[k] !== m_busy[c_addr[k]]) begin n_err++; $display("FAIL rnd_chk%0d c=%0d got=%b exp=%b", k, c, chk_busy[k], m_busy[c_addr[k]]); end
      end
      if (g >= 0) begin
        n_cmp++;
        if (wait_cnt[g] > N - 1) begin n_err++; $display("FAIL rnd_fair req=%0d waited=%0d max=%0d", g, wait_cnt[g], N - 1); end
      end
      for (int j = 0; j < N; j++) begin
        if (j == g) wait_cnt[j] = 0;
        else if (valid[j]) wait_cnt[j]++;
      end
      tick();
      if (g >= 0) valid[g] = 1'b0;
    end
    valid = '0; sb_set = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_midop();
    test_round_robin();
    test_partial();
    test_scoreboard();
    test_collision();
    test_zero_reg();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
